// File: rtl/y86_pkg.sv
// Shared Y86 pipeline constants: status codes, instruction codes, register IDs
// and small helpers used by the pipeline boundary registers.
package y86_pkg;

    // Width of every nibble-sized field (stat, icode, ifun, register IDs)
    localparam int NIBBLE = 4;

    // Status codes
    localparam logic [NIBBLE-1:0] SBUB = 4'h0;
    localparam logic [NIBBLE-1:0] SAOK = 4'h1;
    localparam logic [NIBBLE-1:0] SHLT = 4'h2;
    localparam logic [NIBBLE-1:0] SADR = 4'h3;
    localparam logic [NIBBLE-1:0] SINS = 4'h4;

    // Instruction codes
    localparam logic [NIBBLE-1:0] IHALT   = 4'h0;
    localparam logic [NIBBLE-1:0] INOP    = 4'h1;
    localparam logic [NIBBLE-1:0] IRRMOVQ = 4'h2;
    localparam logic [NIBBLE-1:0] IIRMOVQ = 4'h3;
    localparam logic [NIBBLE-1:0] IRMMOVQ = 4'h4;
    localparam logic [NIBBLE-1:0] IMRMOVQ = 4'h5;
    localparam logic [NIBBLE-1:0] IOPQ    = 4'h6;
    localparam logic [NIBBLE-1:0] IJXX    = 4'h7;
    localparam logic [NIBBLE-1:0] ICALL   = 4'h8;
    localparam logic [NIBBLE-1:0] IRET    = 4'h9;
    localparam logic [NIBBLE-1:0] IPUSHQ  = 4'hA;
    localparam logic [NIBBLE-1:0] IPOPQ   = 4'hB;

    // Function code used by a bubble
    localparam logic [NIBBLE-1:0] FNONE = 4'h0;

    // "No register" identifier
    localparam logic [NIBBLE-1:0] RNONE = 4'hF;

    // Index of each event counter inside a boundary register
    localparam int CNT_STALL  = 0;
    localparam int CNT_BUBBLE = 1;
    localparam int CNT_NUM    = 2;

    // Helper: true when a status nibble marks a bubble rather than an instruction
    function automatic logic is_bubble_stat(input logic [NIBBLE-1:0] stat);
        return (stat == SBUB);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones, and a
// synchronous clear overrides an increment in the same cycle.
module sat_counter
    import y86_pkg::*;
#(
    parameter int CW = 32
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [CW-1:0] count_o
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    // Next count: clear wins, otherwise increment until saturated
    always_comb begin
        count_next = count_reg;
        if (clr_i) begin
            count_next = '0;
        end else if (inc_i && (count_reg != CNT_MAX)) begin
            count_next = count_reg + 1'b1;
        end
    end

    // Count register with asynchronous reset to zero
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count_o = count_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register for one Y86 stage: captures an instruction
// bundle per cycle, with stall (hold), bubble (NOP inject) and saturating
// stall/bubble event counters. Every output comes straight from a flop.
module pipe_stage_reg
    import y86_pkg::*;
#(
    parameter int DW         = 64,
    parameter int CW         = 32,
    parameter bit RST_BUBBLE = 1'b1
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              stall_i,
    input  logic              bubble_i,
    input  logic              cnt_clr_i,
    input  logic [NIBBLE-1:0] in_stat_i,
    input  logic [NIBBLE-1:0] in_icode_i,
    input  logic [NIBBLE-1:0] in_ifun_i,
    input  logic [DW-1:0]     in_valC_i,
    input  logic [DW-1:0]     in_valA_i,
    input  logic [DW-1:0]     in_valB_i,
    input  logic [NIBBLE-1:0] in_srcA_i,
    input  logic [NIBBLE-1:0] in_srcB_i,
    input  logic [NIBBLE-1:0] in_dstE_i,
    input  logic [NIBBLE-1:0] in_dstM_i,
    output logic [NIBBLE-1:0] out_stat_o,
    output logic [NIBBLE-1:0] out_icode_o,
    output logic [NIBBLE-1:0] out_ifun_o,
    output logic [DW-1:0]     out_valC_o,
    output logic [DW-1:0]     out_valA_o,
    output logic [DW-1:0]     out_valB_o,
    output logic [NIBBLE-1:0] out_srcA_o,
    output logic [NIBBLE-1:0] out_srcB_o,
    output logic [NIBBLE-1:0] out_dstE_o,
    output logic [NIBBLE-1:0] out_dstM_o,
    output logic              valid_o,
    output logic [CW-1:0]     stall_cnt_o,
    output logic [CW-1:0]     bubble_cnt_o,
    output logic              conflict_o
);

    // Bundle layout depends on DW, so the struct is declared here
    typedef struct packed {
        logic [NIBBLE-1:0] stat;
        logic [NIBBLE-1:0] icode;
        logic [NIBBLE-1:0] ifun;
        logic [DW-1:0]     valC;
        logic [DW-1:0]     valA;
        logic [DW-1:0]     valB;
        logic [NIBBLE-1:0] srcA;
        logic [NIBBLE-1:0] srcB;
        logic [NIBBLE-1:0] dstE;
        logic [NIBBLE-1:0] dstM;
    } stage_bundle_t;

    localparam stage_bundle_t BUBBLE_BUNDLE = '{
        stat:  SBUB,
        icode: INOP,
        ifun:  FNONE,
        valC:  '0,
        valA:  '0,
        valB:  '0,
        srcA:  RNONE,
        srcB:  RNONE,
        dstE:  RNONE,
        dstM:  RNONE
    };

    // Legacy boundaries reset to all zeros instead of a bubble
    localparam stage_bundle_t RESET_BUNDLE = RST_BUBBLE ? BUBBLE_BUNDLE : stage_bundle_t'('0);

    stage_bundle_t bundle_in;
    stage_bundle_t bundle_reg;
    stage_bundle_t bundle_next;
    logic          valid_reg;
    logic          valid_next;
    logic          conflict_reg;
    logic          conflict_next;

    logic [CNT_NUM-1:0] cnt_inc;
    logic [CW-1:0]      cnt_val [CNT_NUM];

    // Gather the upstream fields into one bundle
    always_comb begin
        bundle_in       = BUBBLE_BUNDLE;
        bundle_in.stat  = in_stat_i;
        bundle_in.icode = in_icode_i;
        bundle_in.ifun  = in_ifun_i;
        bundle_in.valC  = in_valC_i;
        bundle_in.valA  = in_valA_i;
        bundle_in.valB  = in_valB_i;
        bundle_in.srcA  = in_srcA_i;
        bundle_in.srcB  = in_srcB_i;
        bundle_in.dstE  = in_dstE_i;
        bundle_in.dstM  = in_dstM_i;
    end

    // Next bundle: bubble beats stall, stall holds, otherwise capture upstream
    always_comb begin
        bundle_next   = bundle_reg;
        valid_next    = valid_reg;
        conflict_next = stall_i & bubble_i;
        if (bubble_i) begin
            bundle_next = BUBBLE_BUNDLE;
            valid_next  = 1'b0;
        end else if (!stall_i) begin
            bundle_next = bundle_in;
            valid_next  = 1'b1;
        end
    end

    // Bundle, valid and conflict registers with asynchronous reset
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            bundle_reg   <= RESET_BUNDLE;
            valid_reg    <= 1'b0;
            conflict_reg <= 1'b0;
        end else begin
            bundle_reg   <= bundle_next;
            valid_reg    <= valid_next;
            conflict_reg <= conflict_next;
        end
    end

    // A stall only counts when a bubble does not override it
    assign cnt_inc[CNT_STALL]  = stall_i & ~bubble_i;
    assign cnt_inc[CNT_BUBBLE] = bubble_i;

    genvar gi;
    generate
        for (gi = 0; gi < CNT_NUM; gi++) begin : g_cnt
            sat_counter #(
                .CW(CW)
            ) u_cnt (
                .clk_i   (clk_i),
                .rstn_i  (rstn_i),
                .clr_i   (cnt_clr_i),
                .inc_i   (cnt_inc[gi]),
                .count_o (cnt_val[gi])
            );
        end
    endgenerate

    assign out_stat_o   = bundle_reg.stat;
    assign out_icode_o  = bundle_reg.icode;
    assign out_ifun_o   = bundle_reg.ifun;
    assign out_valC_o   = bundle_reg.valC;
    assign out_valA_o   = bundle_reg.valA;
    assign out_valB_o   = bundle_reg.valB;
    assign out_srcA_o   = bundle_reg.srcA;
    assign out_srcB_o   = bundle_reg.srcB;
    assign out_dstE_o   = bundle_reg.dstE;
    assign out_dstM_o   = bundle_reg.dstM;
    assign valid_o      = valid_reg;
    assign conflict_o   = conflict_reg;
    assign stall_cnt_o  = cnt_val[CNT_STALL];
    assign bubble_cnt_o = cnt_val[CNT_BUBBLE];

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised successor to the fixed Y86 execute-stage register. Captures one instruction bundle (stat, icode, ifun, valC, valA, valB, srcA, srcB, dstE, dstM) per cycle and adds three behaviours: stall (hold), bubble (inject NOP), and per-stage stall/bubble event counters. It is instantiated once per pipeline boundary (F/D, D/E, E/M, M/W); unused fields are tied off by the parent.

## Interface
- `DW`, default 64: data word width for valC/valA/valB.
- `CW`, default 32: width of each event counter.
- `RST_BUBBLE`, default 1: 1 = reset loads the bubble bundle; 0 = reset loads all zeros (legacy).
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rstn_i` in 1: reset, asynchronous and active-low.
- `stall_i` in 1: hold the current contents.
- `bubble_i` in 1: load the bubble bundle.
- `cnt_clr_i` in 1: synchronous clear of both counters.
- `in_stat_i`, `in_icode_i`, `in_ifun_i` in 4 each: upstream status, icode, ifun.
- `in_valC_i`, `in_valA_i`, `in_valB_i` in DW each: upstream data words.
- `in_srcA_i`, `in_srcB_i`, `in_dstE_i`, `in_dstM_i` in 4 each: register IDs.
- `out_*_o` out, same widths: registered bundle, one output per input field.
- `valid_o` out 1: 1 when the held bundle is a real instruction, not a bubble.
- `stall_cnt_o` out CW: cycles in which a stall took effect.
- `bubble_cnt_o` out CW: cycles in which a bubble was loaded.
- `conflict_o` out 1: registered flag, 1 for one cycle after stall_i and bubble_i were both high.

## Operation
- Bubble bundle: stat=SBUB (4'h0), icode=INOP (4'h1), ifun=0, valC/valA/valB=0, srcA/srcB/dstE/dstM=RNONE (4'hF).
- Per-edge priority, highest first:
  1. reset
  2. bubble_i: load the bubble bundle, valid_o<=0.
  3. stall_i: hold every field and valid_o.
  4. otherwise: load the in_* fields, valid_o<=1.
- A bubble always wins over a stall. When both are high, the bubble loads, only bubble_cnt increments, and conflict_o<=1 on the next cycle; otherwise conflict_o<=0.
- A stall while valid_o=0 still holds the bubble and still counts.
- Counters:
  - stall_cnt increments in a cycle with stall_i=1 and bubble_i=0.
  - bubble_cnt increments in a cycle with bubble_i=1.
  - Both saturate at 2^CW-1; they do not wrap.
  - cnt_clr_i has priority over an increment in the same cycle: the counter becomes 0, not 1.
  - The counters are independent of the pipeline path; cnt_clr_i never touches the bundle.
- Width rules: DW fields pass unmodified. There is no sign or zero extension inside the block.

## Timing
- Latency is one cycle from in_* to out_* when neither control is asserted.
- All outputs are registered. There is no combinational path from any input to any output.
- Reset values (rstn_i low, asynchronous):
  - RST_BUBBLE=1: the bubble bundle.
  - RST_BUBBLE=0: all bundle fields 0.
  - In both modes: valid_o=0, both counters 0, conflict_o=0.
- Deassertion of rstn_i is synchronised by the parent. The first capture happens on the first rising edge with rstn_i high.
- Reset asserted mid-stall or mid-bubble clears immediately. The pending control has no effect after release.
- stall_i, bubble_i and cnt_clr_i are sampled on the same edge as the data. The controls are level-sensitive with no internal memory, so a multi-cycle stall holds for exactly as many cycles as stall_i is high.

## Structure
- Shared package `y86_pkg` holds:
  - status codes: SAOK=1, SHLT=2, SADR=3, SINS=4, SBUB=0
  - ICODE constants (INOP=1, etc.) and RNONE=4'hF
  - NIBBLE width = 4
  - a packed `stage_bundle_t` struct parametrised by DW via typedef in the parent
- One sub-module: `sat_counter` (CW-wide, inc/clr, saturating), instantiated twice.
- The bundle register itself stays inline.

## Test plan
- Reset with RST_BUBBLE=1, hold rstn_i low across 3 edges → out_icode=1, out_stat=0, srcA/srcB/dstE/dstM=4'hF, valid_o=0, counters 0.
- Pass-through: drive icode=6, ifun=0, valA=64'h5, valB=64'h7, dstE=4'h2, no controls → the same values appear on out_* one edge later, valid_o=1.
- Stall 3 cycles while inputs change every cycle → out_* frozen at the pre-stall bundle, stall_cnt=3. On release, the next edge loads the current inputs.
- stall_i=1 and bubble_i=1 together for one edge → bubble bundle loads, bubble_cnt=1, stall_cnt unchanged, conflict_o=1 for exactly one cycle.
- CW=4, bubble held 20 cycles → bubble_cnt reaches 15 and stays. cnt_clr_i asserted with bubble_i still high → counter reads 0 after that edge, 1 after the next.
- Assert rstn_i low asynchronously mid-cycle during a stall → outputs take the reset values before the next edge. After release, normal capture resumes with stall_cnt counting from 0.
